// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// FSM states and the byte-lane mask helper.
package data_memory_responder_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Byte lanes touched by an access; lo must already be aligned to the size.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] mask;
        mask = 4'b1111;
        case (size)
            SIZE_BYTE: mask = 4'b0001 << lo;
            SIZE_HALF: mask = lo[1] ? 4'b1100 : 4'b0011;
            default:   mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/data_memory_responder_load_aligner.sv
// Combinational load aligner: selects the addressed byte/half of a word and
// sign- or zero-extends it to 32 bits. Also usable in the core's load path.
module load_aligner
    import data_memory_responder_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        o_data = i_word;
        case (i_size)
            SIZE_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SIZE_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default:   o_data = i_word;
        endcase
    end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: one outstanding load/store, WAIT_STATES wait states,
// registered response. Define DMEM_ERR_EN to report misaligned/out-of-range/
// reserved-size requests as errors instead of silently aligning and wrapping.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iValid,
    output logic        oReady,
    input  logic        iWrite,
    input  logic [1:0]  iSize,
    input  logic        iUnsigned,
    input  logic [31:0] iAddress,
    input  logic [31:0] iData,
    output logic        oValid,
    input  logic        iAccept,
    output logic [31:0] oData,
    output logic        oError
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_valid;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_commit;
    logic          w_req_write;
    logic [1:0]    w_req_size;
    logic          w_req_unsigned;
    logic [31:0]   w_req_addr;
    logic [31:0]   w_req_data;
    logic [1:0]    w_size_n;
    logic [1:0]    w_lo;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_mask;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rd_word;
    logic [31:0]   w_load_data;

    assign w_accept = iValid && (r_state == ST_IDLE);

    // With zero wait states the commit lands on the acceptance edge, so the
    // live inputs are used while idle and the latched copy afterwards.
    assign w_req_write    = (r_state == ST_IDLE) ? iWrite    : r_write;
    assign w_req_size     = (r_state == ST_IDLE) ? iSize     : r_size;
    assign w_req_unsigned = (r_state == ST_IDLE) ? iUnsigned : r_unsigned;
    assign w_req_addr     = (r_state == ST_IDLE) ? iAddress  : r_addr;
    assign w_req_data     = (r_state == ST_IDLE) ? iData     : r_data;

    assign w_commit = (w_accept && (WAIT_STATES == 0)) ||
                      ((r_state == ST_WAIT) && (r_cnt == 4'd1));

`ifdef DMEM_ERR_EN
    assign w_size_n = w_req_size;
    assign w_lo     = w_req_addr[1:0];
    assign w_err    = (w_req_size == SIZE_RSVD) ||
                      ((w_req_size == SIZE_HALF) && w_req_addr[0]) ||
                      ((w_req_size == SIZE_WORD) && (w_req_addr[1:0] != 2'b00)) ||
                      (|w_req_addr[31:AW+2]);
`else
    logic w_unused_addr_hi;

    assign w_size_n = (w_req_size == SIZE_RSVD) ? SIZE_WORD : w_req_size;
    assign w_lo     = (w_size_n == SIZE_BYTE) ? w_req_addr[1:0] :
                      (w_size_n == SIZE_HALF) ? {w_req_addr[1], 1'b0} : 2'b00;
    assign w_err    = 1'b0;
    assign w_unused_addr_hi = ^w_req_addr[31:AW+2];
`endif

    assign w_idx     = w_req_addr[AW+1:2];
    assign w_mask    = lane_mask(w_size_n, w_lo);
    assign w_wdata   = (w_size_n == SIZE_BYTE) ? {4{w_req_data[7:0]}} :
                       (w_size_n == SIZE_HALF) ? {2{w_req_data[15:0]}} : w_req_data;
    assign w_rd_word = r_mem[w_idx];

    load_aligner u_load_aligner (
        .i_word     (w_rd_word),
        .i_addr_lo  (w_lo),
        .i_size     (w_size_n),
        .i_unsigned (w_req_unsigned),
        .o_data     (w_load_data)
    );

    // Array contents survive reset; reset only blocks a commit in flight.
    always_ff @(posedge clock) begin
        if (w_commit && w_req_write && !w_err && !reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_mask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        oReady       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                oReady = 1'b1;
                if (iValid) begin
                    w_state_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (iAccept) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_write    <= iWrite;
                r_size     <= iSize;
                r_unsigned <= iUnsigned;
                r_addr     <= iAddress;
                r_data     <= iData;
                r_cnt      <= 4'(WAIT_STATES);
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_valid <= 1'b1;
                r_rdata <= (!w_req_write && !w_err) ? w_load_data : '0;
                r_err   <= w_err;
            end else if ((r_state == ST_RESP) && iAccept) begin
                r_valid <= 1'b0;
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    assign oValid = r_valid;
    assign oData  = r_rdata;
    assign oError = r_err;

endmodule
